led_chaser_ctrl: RTL and testbench

- Upstream control stage for the 8-LED chaser.
- Takes two raw push buttons (start/stop, mode) and produces the chaser's level controls SS and MODE, plus a slow step strobe TICK used as the chaser's clock enable.
- Sits between board I/O pins and the LED pattern block. Everything runs on the single system clock.

---
 rtl/led_chaser_pkg.sv | 26 ++
 rtl/led_chaser_ctrl_if.sv | 37 +++
 rtl/led_chaser_ctrl_btn_debounce.sv | 69 ++++++
 rtl/led_chaser_ctrl.sv | 100 ++++++++++
 tb/tb_led_chaser_ctrl.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/led_chaser_pkg.sv
// ---------------------------------------------------------------------------
// led_chaser_pkg
// Shared definitions for the LED chaser control stage:
//   cnt_w()        counter width helper, never narrower than one bit
//   MODE_OUT_IN    MODE level selecting the outside-in pattern
//   MODE_CTR_OUT   MODE level selecting the centre-out pattern
//   btn_idx_e      index of each button inside the packed button vectors
// ---------------------------------------------------------------------------
package led_chaser_pkg;

    localparam logic MODE_OUT_IN  = 1'b1;
    localparam logic MODE_CTR_OUT = 1'b0;

    localparam int NUM_BTN = 2;

    typedef enum int {
        BTN_IDX_SS   = 0,
        BTN_IDX_MODE = 1
    } btn_idx_e;

    // Width needed to count 0 .. n-1; a zero-width vector is never legal.
    function automatic int cnt_w(input int n);
        return ($clog2(n) > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_chaser_ctrl_if.sv
// ---------------------------------------------------------------------------
// led_chaser_ctrl_if
// Groups the board-facing buttons and the chaser-facing controls.
//   BTN_SS, BTN_MODE          raw push buttons (active-high, bouncy)
//   SS, MODE, TICK, MODE_CHG  control levels and strobes for the chaser
// Modports:
//   master  the board / pattern side: drives buttons, consumes controls
//   slave   the control stage itself: consumes buttons, drives controls
// ---------------------------------------------------------------------------
interface led_chaser_ctrl_if;

    logic BTN_SS;
    logic BTN_MODE;
    logic SS;
    logic MODE;
    logic TICK;
    logic MODE_CHG;

    modport master (
        output BTN_SS,
        output BTN_MODE,
        input  SS,
        input  MODE,
        input  TICK,
        input  MODE_CHG
    );

    modport slave (
        input  BTN_SS,
        input  BTN_MODE,
        output SS,
        output MODE,
        output TICK,
        output MODE_CHG
    );

endinterface

// File: rtl/led_chaser_ctrl_btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// One push-button conditioning path: 2-flop synchroniser, debounce counter
// and rising-edge detector on the debounced level.
//   Clk      system clock (rising edge)
//   RST      synchronous reset, active-low
//   btn_raw  raw asynchronous button level
//   stable   debounced button level
//   press    one-cycle pulse, the cycle after stable rises
// ---------------------------------------------------------------------------
module btn_debounce
    import led_chaser_pkg::*;
#(
    parameter int DEB_CNT = 1_000_000
) (
    input  logic Clk,
    input  logic RST,
    input  logic btn_raw,
    output logic stable,
    output logic press
);

    localparam int             CW       = cnt_w(DEB_CNT);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CNT - 1);

    logic          sync_meta_reg;
    logic          sync_reg;
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;
    logic          stable_reg;
    logic          stable_next;
    logic          stable_d_reg;

    // The counter only advances while the synchronised level disagrees with
    // the accepted level; any agreement restarts the qualification window.
    always_comb begin
        cnt_next    = '0;
        stable_next = stable_reg;
        if (sync_reg != stable_reg) begin
            if (cnt_reg == CNT_LAST) begin
                stable_next = sync_reg;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!RST) begin
            sync_meta_reg <= 1'b0;
            sync_reg      <= 1'b0;
            cnt_reg       <= '0;
            stable_reg    <= 1'b0;
            stable_d_reg  <= 1'b0;
        end else begin
            sync_meta_reg <= btn_raw;
            sync_reg      <= sync_meta_reg;
            cnt_reg       <= cnt_next;
            stable_reg    <= stable_next;
            stable_d_reg  <= stable_reg;
        end
    end

    assign stable = stable_reg;
    // Both operands are flops, so press is glitch-free and is high for the
    // single cycle following the edge on which stable rose.
    assign press  = stable_reg & ~stable_d_reg;

endmodule

// File: rtl/led_chaser_ctrl.sv
// ---------------------------------------------------------------------------
// led_chaser_ctrl
// Control stage ahead of the 8-LED chaser: debounces the two buttons,
// toggles run enable and pattern select on presses, and divides the clock
// down to the chaser step strobe.
//   Clk   system clock (rising edge)
//   RST   synchronous reset, active-low
//   bus   led_chaser_ctrl_if.slave
//         BTN_SS / BTN_MODE in; SS, MODE, TICK, MODE_CHG out
// ---------------------------------------------------------------------------
module led_chaser_ctrl
    import led_chaser_pkg::*;
#(
    parameter int DEB_CNT  = 1_000_000,
    parameter int TICK_DIV = 25_000_000
) (
    input  logic               Clk,
    input  logic               RST,
    led_chaser_ctrl_if.slave   bus
);

    localparam int            PW       = cnt_w(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_press;
    // Debounced levels are not needed here; only the press edges matter.
    logic [NUM_BTN-1:0] btn_stable_unused;

    assign btn_raw[BTN_IDX_SS]   = bus.BTN_SS;
    assign btn_raw[BTN_IDX_MODE] = bus.BTN_MODE;

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            btn_debounce #(
                .DEB_CNT (DEB_CNT)
            ) u_debounce (
                .Clk     (Clk),
                .RST     (RST),
                .btn_raw (btn_raw[gi]),
                .stable  (btn_stable_unused[gi]),
                .press   (btn_press[gi])
            );
        end
    endgenerate

    logic          ss_press;
    logic          mode_press;
    logic          ss_reg,       ss_next;
    logic          mode_reg,     mode_next;
    logic          mode_chg_reg, mode_chg_next;
    logic          tick_reg,     tick_next;
    logic [PW-1:0] pre_reg,      pre_next;

    assign ss_press   = btn_press[BTN_IDX_SS];
    assign mode_press = btn_press[BTN_IDX_MODE];

    // The prescaler looks at the pre-toggle SS, so a stop press landing on a
    // wrap still lets that final step through. A mode change restarts the
    // period so the reloaded seed is shown for a full step.
    always_comb begin
        ss_next       = ss_reg ^ ss_press;
        mode_next     = mode_reg ^ mode_press;
        mode_chg_next = mode_press;
        pre_next      = pre_reg;
        tick_next     = 1'b0;
        if (mode_press) begin
            pre_next = '0;
        end else if (ss_reg) begin
            if (pre_reg == PRE_LAST) begin
                pre_next  = '0;
                tick_next = 1'b1;
            end else begin
                pre_next = pre_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!RST) begin
            ss_reg       <= 1'b0;
            mode_reg     <= MODE_CTR_OUT;
            mode_chg_reg <= 1'b0;
            tick_reg     <= 1'b0;
            pre_reg      <= '0;
        end else begin
            ss_reg       <= ss_next;
            mode_reg     <= mode_next;
            mode_chg_reg <= mode_chg_next;
            tick_reg     <= tick_next;
            pre_reg      <= pre_next;
        end
    end

    assign bus.SS       = ss_reg;
    assign bus.MODE     = mode_reg;
    assign bus.TICK     = tick_reg;
    assign bus.MODE_CHG = mode_chg_reg;

endmodule

// File: tb/tb_led_chaser_ctrl.sv
// ---------------------------------------------------------------------------
// tb_led_chaser_ctrl
// Directed bench for led_chaser_ctrl with DEB_CNT=4, TICK_DIV=5.
// A per-cycle vector table covers reset and the simultaneous first press;
// hand-written sequences cover tick rate, mode change, pause/resume,
// bounce rejection and reset during a debounce.
// ---------------------------------------------------------------------------
module tb_led_chaser_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    led_chaser_ctrl_if bus_if ();

    led_chaser_ctrl #(
        .DEB_CNT  (4),
        .TICK_DIV (5)
    ) dut (
        .Clk (clk),
        .RST (rst_n),
        .bus (bus_if)
    );

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic       rst;
        logic       bss;
        logic       bmode;
        logic [3:0] exp;   // {SS, MODE, TICK, MODE_CHG}
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] outs();
        return {bus_if.SS, bus_if.MODE, bus_if.TICK, bus_if.MODE_CHG};
    endfunction

    task automatic wait_tick(input string name);
        int k = 0;
        while (k < 20 && bus_if.TICK !== 1'b1) begin
            step();
            k++;
        end
        chk(name, 32'(bus_if.TICK), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int ticks;

        // Reset held 3 cycles with both buttons high, then both debounced
        // together: first press lands 7 edges after release.
        for (int i = 0; i < 16; i++) begin
            vecs[i].rst   = (i >= 3);
            vecs[i].bss   = 1'b1;
            vecs[i].bmode = 1'b1;
            vecs[i].exp   = 4'b0000;
        end
        vecs[9].exp  = 4'b1101;
        vecs[10].exp = 4'b1100;
        vecs[11].exp = 4'b1100;
        vecs[12].exp = 4'b1100;
        vecs[13].exp = 4'b1100;
        vecs[14].exp = 4'b1110;
        vecs[15].exp = 4'b1100;

        bus_if.BTN_SS   = 1'b1;
        bus_if.BTN_MODE = 1'b1;

        for (int i = 0; i < 16; i++) begin
            rst_n           = vecs[i].rst;
            bus_if.BTN_SS   = vecs[i].bss;
            bus_if.BTN_MODE = vecs[i].bmode;
            step();
            $display("vec %0d rst=%b ss_btn=%b mode_btn=%b outs=%b exp=%b",
                     i, vecs[i].rst, vecs[i].bss, vecs[i].bmode, outs(), vecs[i].exp);
            chk($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
        end

        // Tick rate: exactly one pulse every 5 cycles while running.
        ticks = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (bus_if.TICK === 1'b1) ticks++;
        end
        $display("tick rate: %0d pulses in 100 cycles", ticks);
        chk("tick_count", 32'(ticks), 20);

        // Mode change timed so the press lands with the prescaler at 4.
        bus_if.BTN_MODE = 1'b0;
        repeat (10) step();
        chk("mode_release_no_toggle", 32'(bus_if.MODE), 1);
        wait_tick("mode_sync_tick");
        repeat (3) step();
        bus_if.BTN_MODE = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("mode_hold%0d", i), 32'(bus_if.MODE), 1);
        end
        step();
        $display("mode change: MODE=%b MODE_CHG=%b TICK=%b", bus_if.MODE, bus_if.MODE_CHG, bus_if.TICK);
        chk("mode_toggle", 32'(bus_if.MODE), 0);
        chk("mode_chg_pulse", 32'(bus_if.MODE_CHG), 1);
        chk("tick_suppressed", 32'(bus_if.TICK), 0);
        for (int i = 1; i < 5; i++) begin
            step();
            chk($sformatf("post_chg_tick%0d", i), 32'(bus_if.TICK), 0);
            if (i == 1) chk("mode_chg_one_cycle", 32'(bus_if.MODE_CHG), 0);
        end
        step();
        chk("tick_after_chg", 32'(bus_if.TICK), 1);

        // Pause two counts into a period, idle 13 cycles, resume.
        bus_if.BTN_SS = 1'b0;
        repeat (10) step();
        chk("ss_release_no_toggle", 32'(bus_if.SS), 1);
        wait_tick("pause_sync_tick");
        bus_if.BTN_SS = 1'b1;
        repeat (6) step();
        chk("ss_before_stop", 32'(bus_if.SS), 1);
        step();
        chk("ss_stop", 32'(bus_if.SS), 0);
        chk("stop_no_tick", 32'(bus_if.TICK), 0);
        bus_if.BTN_SS = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("paused_a%0d", i), 32'({bus_if.SS, bus_if.TICK}), 0);
        end
        bus_if.BTN_SS = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("paused_b%0d", i), 32'({bus_if.SS, bus_if.TICK}), 0);
        end
        step();
        $display("resume: SS=%b", bus_if.SS);
        chk("resume_ss", 32'(bus_if.SS), 1);
        chk("resume_tick0", 32'(bus_if.TICK), 0);
        step();
        chk("resume_tick1", 32'(bus_if.TICK), 0);
        step();
        chk("resume_tick2", 32'(bus_if.TICK), 0);
        step();
        chk("resume_tick3", 32'(bus_if.TICK), 1);

        // Bounce rejection: 3-high/1-low bursts never qualify.
        bus_if.BTN_SS = 1'b0;
        repeat (10) step();
        for (int r = 0; r < 5; r++) begin
            bus_if.BTN_SS = 1'b1;
            repeat (3) step();
            bus_if.BTN_SS = 1'b0;
            step();
            chk($sformatf("bounce%0d", r), 32'(bus_if.SS), 1);
        end
        bus_if.BTN_SS = 1'b1;
        repeat (6) step();
        chk("bounce_not_yet", 32'(bus_if.SS), 1);
        step();
        $display("bounce settle: SS=%b", bus_if.SS);
        chk("bounce_accept", 32'(bus_if.SS), 0);
        bus_if.BTN_SS = 1'b0;
        repeat (10) step();
        bus_if.BTN_SS = 1'b1;
        repeat (7) step();
        chk("repress", 32'(bus_if.SS), 1);

        // Reset two cycles into a debounce restarts qualification.
        bus_if.BTN_SS   = 1'b0;
        bus_if.BTN_MODE = 1'b0;
        repeat (10) step();
        bus_if.BTN_SS = 1'b1;
        repeat (4) step();
        rst_n = 1'b0;
        repeat (2) step();
        chk("reset_mid", 32'(outs()), 0);
        rst_n = 1'b1;
        repeat (6) step();
        chk("no_early_toggle", 32'(bus_if.SS), 0);
        step();
        $display("post-reset press: SS=%b MODE=%b", bus_if.SS, bus_if.MODE);
        chk("toggle_after_full", 32'(bus_if.SS), 1);
        chk("mode_after_reset", 32'(bus_if.MODE), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
